// File: rtl/run_sequencer.sv
// Host-side run controller: preloads core data memory, holds/releases core reset,
// counts RUN cycles until core_done. Optional watchdog abort via RUN_SEQ_WATCHDOG_EN.
module run_sequencer #(
  parameter int          AW      = 8,
  parameter int          DW      = 8,
  parameter int          CW      = 16,
  parameter int          RST_CYC = 2,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          busy,
  output logic          run_done,
  output logic          timed_out,
  output logic [CW-1:0] cycle_cnt,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_RUN, S_DONE, S_TMO} state_t;

  localparam int RW = (RST_CYC < 2) ? 1 : $clog2(RST_CYC + 1);

  state_t        state_q;
  logic [RW-1:0] rst_cnt_q;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic          ld_ready_q, busy_q, run_done_q, timed_out_q;
  logic          core_reset_q, core_req_q;
  logic          accept, tmo_hit;

  assign accept      = ld_ready_q && ld_valid;
  assign cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;

`ifdef RUN_SEQ_WATCHDOG_EN
  assign tmo_hit = (cycle_cnt_q == CW'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (cycle_cnt_q == CW'(TIMEOUT));
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      ld_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      timed_out_q  <= 1'b0;
      core_reset_q <= 1'b1;
      core_req_q   <= 1'b0;
    end else begin
      core_req_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_TMO: begin
          if (start) begin
            state_q     <= S_LOAD;
            ld_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            run_done_q  <= 1'b0;
            timed_out_q <= 1'b0;
            cycle_cnt_q <= '0;
          end
        end
        S_LOAD: begin
          if (accept && ld_last) begin
            state_q    <= S_RST;
            ld_ready_q <= 1'b0;
            rst_cnt_q  <= RW'(RST_CYC);
          end
        end
        S_RST: begin
          if (rst_cnt_q == RW'(1)) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
            core_req_q   <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          // A completion in the same cycle as the watchdog limit counts as a normal finish.
          if (core_done) begin
            state_q      <= S_DONE;
            run_done_q   <= 1'b1;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            cycle_cnt_q <= cycle_cnt_d;
            if (tmo_hit) begin
              state_q      <= S_TMO;
              timed_out_q  <= 1'b1;
              core_reset_q <= 1'b1;
              busy_q       <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ld_ready   = ld_ready_q;
  assign busy       = busy_q;
  assign run_done   = run_done_q;
  assign timed_out  = timed_out_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign core_reset = core_reset_q;
  assign core_req   = core_req_q;

  // Zero-latency write path; a beat coinciding with reset is dropped.
  assign mem_wr_en = accept && !reset;
  assign mem_addr  = ld_addr;
  assign mem_dat   = ld_data;

endmodule
